pc_unit: RTL and testbench
==========================

# pc_unit

Registered program-counter unit: the parametrised successor of the combinational PC incrementer. Holds the architectural PC and computes the next PC each cycle from one of five operations: sequential, relative branch, absolute jump, call, return. Includes a return-address stack (RAS) and a stall input. Sits at the head of the fetch stage and drives the instruction-memory address.

## Interface
- REG_WIDTH, 32: PC / address width in bits.
- STEP, 1: sequential increment in address units. Word-addressed memory, so the default is 1.
- RESET_VECTOR, 0: PC value after reset.
- RAS_DEPTH, 4: return-address stack entries. Power of two, ≥2.

Ports:
- i_clk  in  1  clock, all state updates on the rising edge.
- i_rst_n  in  1  synchronous, active-low reset.
- i_stall  in  1  1 = hold PC and RAS, ignore i_op.
- i_op  in  3  000 SEQ, 001 BRANCH, 010 JUMP, 011 CALL, 100 RET. 101–111 are treated as SEQ.
- i_offset  in  REG_WIDTH  signed two's-complement branch offset, used by BRANCH.
- i_target  in  REG_WIDTH  absolute target, used by JUMP and CALL.
- o_pc  out  REG_WIDTH  current PC (registered).
- o_ras_count  out  $clog2(RAS_DEPTH)+1  valid RAS entries.
- o_ras_empty  out  1  o_ras_count == 0.
- o_ras_full  out  1  o_ras_count == RAS_DEPTH.
- o_ras_overflow  out  1  registered 1-cycle pulse: a CALL overwrote the oldest entry.
- o_ras_underflow  out  1  registered 1-cycle pulse: a RET was issued on an empty RAS.

## Operation
Next PC per op, applied at the edge when i_stall = 0:
- SEQ: PC + STEP.
- BRANCH: PC + i_offset.
- JUMP: i_target.
- CALL: i_target; push PC + STEP.
- RET, RAS non-empty: pop the top entry; PC = popped value.
- RET, RAS empty: PC = PC + STEP; RAS unchanged; pulse o_ras_underflow.

Arithmetic:
- All arithmetic is modulo 2^REG_WIDTH; carry out is discarded.
- 0xFFFF_FFFF + 1 wraps to 0. A negative offset below 0 wraps to the top of the address space.

RAS:
- Circular buffer with a top pointer and a saturating count.
- CALL when full: the push overwrites the oldest entry, the top advances, count stays RAS_DEPTH, and o_ras_overflow pulses.
- Pop order is always LIFO over the most recent RAS_DEPTH pushes.

Stall:
- i_stall = 1 holds o_pc and all RAS state.
- No pulses are generated. Any op presented during the stall is discarded, not queued.

## Timing
- Latency is 1 cycle: i_op is sampled at edge N and o_pc shows the result after edge N.
- One op per cycle with no bubbles; back-to-back CALL/RET is legal every cycle.
- Flag timing:
  - o_ras_empty and o_ras_full are combinational from the count, so they reflect state after the last edge.
  - The overflow and underflow pulses are high for exactly the cycle after the offending edge, then return to 0 unless re-triggered.
- Reset (i_rst_n = 0 at an edge) has priority over everything, including i_stall:
  - o_pc = RESET_VECTOR.
  - o_ras_count = 0, o_ras_empty = 1, o_ras_full = 0.
  - Pulses = 0. RAS contents are don't-care.
- A reset asserted mid-sequence discards all pending return addresses. The first op after release executes from RESET_VECTOR.

## Test plan
- Reset, then 3 SEQ cycles with STEP = 1 → o_pc 0, 1, 2, 3. Any i_op with i_rst_n = 0 → o_pc stays 0.
- PC = 10, BRANCH offset 42 → 52. BRANCH offset −60 (0xFFFF_FFC4) → 0xFFFF_FFF8. From 0xFFFF_FFFF, SEQ → 0.
- PC = 5, CALL target 100 → PC 100 with RAS top 6. SEQ twice → 102. RET → 6, o_ras_empty = 1.
- RAS_DEPTH = 4, CALLs from PCs 0, 100, 200, 300, 400 (targets 100…500) → o_ras_overflow pulses once, on the cycle after the 5th CALL; count = 4. Four RETs → 401, 301, 201, 101.
- RET with empty RAS at PC 7 → PC 8, o_ras_underflow high exactly one cycle, count stays 0.
- i_stall = 1 for 3 cycles while i_op = JUMP 0x80 → o_pc and o_ras_count unchanged and no pulses. Release with SEQ → PC + 1; the JUMP is not taken.

Source files
------------

// File: rtl/pc_unit.sv
// pc_unit: registered program counter with a circular return-address stack.
// Next PC is chosen from SEQ / BRANCH / JUMP / CALL / RET every cycle unless stalled.
module pc_unit #(
  parameter int unsigned            REG_WIDTH    = 32,
  parameter int unsigned            STEP         = 1,
  parameter logic [REG_WIDTH-1:0]   RESET_VECTOR = '0,
  parameter int unsigned            RAS_DEPTH    = 4
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic                           i_stall,
  input  logic [2:0]                     i_op,
  input  logic [REG_WIDTH-1:0]           i_offset,
  input  logic [REG_WIDTH-1:0]           i_target,
  output logic [REG_WIDTH-1:0]           o_pc,
  output logic [$clog2(RAS_DEPTH):0]     o_ras_count,
  output logic                           o_ras_empty,
  output logic                           o_ras_full,
  output logic                           o_ras_overflow,
  output logic                           o_ras_underflow
);

  localparam int unsigned PW = $clog2(RAS_DEPTH);
  localparam int unsigned CW = PW + 1;

  localparam logic [2:0] OP_SEQ    = 3'b000;
  localparam logic [2:0] OP_BRANCH = 3'b001;
  localparam logic [2:0] OP_JUMP   = 3'b010;
  localparam logic [2:0] OP_CALL   = 3'b011;
  localparam logic [2:0] OP_RET    = 3'b100;

  localparam logic [REG_WIDTH-1:0] STEP_W  = REG_WIDTH'(STEP);
  localparam logic [CW-1:0]        DEPTH_C = CW'(RAS_DEPTH);

  logic [REG_WIDTH-1:0] pc_q;
  logic [CW-1:0]        count_q;
  // wptr_q is the slot the next push writes; the top entry sits at wptr_q - 1.
  logic [PW-1:0]        wptr_q;
  logic                 ovf_q;
  logic                 unf_q;
  logic [REG_WIDTH-1:0] ras_mem [RAS_DEPTH];

  logic [REG_WIDTH-1:0] pc_seq;
  logic [REG_WIDTH-1:0] pc_next;
  logic [PW-1:0]        top_idx;
  logic                 ras_empty;
  logic                 ras_full;
  logic                 do_push;
  logic                 do_pop;
  logic                 ovf_next;
  logic                 unf_next;

  assign pc_seq    = pc_q + STEP_W;
  assign top_idx   = wptr_q - PW'(1);
  assign ras_empty = (count_q == '0);
  assign ras_full  = (count_q == DEPTH_C);

  // Decode the operation into next PC, stack push/pop and pulse requests.
  always_comb begin
    pc_next  = pc_seq;
    do_push  = 1'b0;
    do_pop   = 1'b0;
    ovf_next = 1'b0;
    unf_next = 1'b0;
    if (!i_stall) begin
      case (i_op)
        OP_BRANCH: pc_next = pc_q + i_offset;
        OP_JUMP:   pc_next = i_target;
        OP_CALL: begin
          pc_next  = i_target;
          do_push  = 1'b1;
          ovf_next = ras_full;
        end
        OP_RET: begin
          if (ras_empty) begin
            unf_next = 1'b1;
          end else begin
            pc_next = ras_mem[top_idx];
            do_pop  = 1'b1;
          end
        end
        default: pc_next = pc_seq;
      endcase
    end else begin
      pc_next = pc_q;
    end
  end

  // PC, stack pointer, saturating count and one-cycle pulses.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      pc_q    <= RESET_VECTOR;
      count_q <= '0;
      wptr_q  <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      pc_q  <= pc_next;
      ovf_q <= ovf_next;
      unf_q <= unf_next;
      if (do_push) begin
        wptr_q <= wptr_q + PW'(1);
        if (!ras_full) count_q <= count_q + CW'(1);
      end else if (do_pop) begin
        wptr_q  <= top_idx;
        count_q <= count_q - CW'(1);
      end
    end
  end

  // Stack storage; contents are don't-care after reset so no reset is applied.
  always_ff @(posedge i_clk) begin
    if (i_rst_n && do_push) ras_mem[wptr_q] <= pc_seq;
  end

  assign o_pc            = pc_q;
  assign o_ras_count     = count_q;
  assign o_ras_empty     = ras_empty;
  assign o_ras_full      = ras_full;
  assign o_ras_overflow  = ovf_q;
  assign o_ras_underflow = unf_q;

endmodule

// File: tb/tb_pc_unit.sv
// Testbench for pc_unit: directed scenarios plus random ops, checked by a
// scoreboard against a queue-based reference model.
module tb_pc_unit;

  localparam int unsigned W     = 32;
  localparam int unsigned DEPTH = 4;
  localparam logic [W-1:0] RV   = '0;

  logic         clk;
  logic         rst_n;
  logic         stall;
  logic [2:0]   op;
  logic [W-1:0] offset;
  logic [W-1:0] target;
  logic [W-1:0] pc;
  logic [2:0]   ras_count;
  logic         ras_empty;
  logic         ras_full;
  logic         ras_ovf;
  logic         ras_unf;

  pc_unit #(
    .REG_WIDTH   (W),
    .STEP        (1),
    .RESET_VECTOR(RV),
    .RAS_DEPTH   (DEPTH)
  ) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_stall        (stall),
    .i_op           (op),
    .i_offset       (offset),
    .i_target       (target),
    .o_pc           (pc),
    .o_ras_count    (ras_count),
    .o_ras_empty    (ras_empty),
    .o_ras_full     (ras_full),
    .o_ras_overflow (ras_ovf),
    .o_ras_underflow(ras_unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] pc;
    int           count;
    logic         ovf;
    logic         unf;
  } exp_t;

  exp_t         sb[$];
  int           n_cmp = 0;
  int           n_err = 0;

  // Reference model: architectural PC and a bounded LIFO of return addresses.
  logic [W-1:0] m_pc;
  logic [W-1:0] m_ras[$];

  task automatic step(input logic r, input logic s, input logic [2:0] o,
                      input logic [W-1:0] off, input logic [W-1:0] tgt);
    exp_t e;
    @(negedge clk);
    rst_n  = r;
    stall  = s;
    op     = o;
    offset = off;
    target = tgt;
    @(posedge clk);
    e.ovf = 1'b0;
    e.unf = 1'b0;
    if (!r) begin
      m_pc = RV;
      m_ras.delete();
    end else if (!s) begin
      case (o)
        3'd1: m_pc = m_pc + off;
        3'd2: m_pc = tgt;
        3'd3: begin
          m_ras.push_back(m_pc + 1);
          if (m_ras.size() > DEPTH) begin
            void'(m_ras.pop_front());
            e.ovf = 1'b1;
          end
          m_pc = tgt;
        end
        3'd4: begin
          if (m_ras.size() > 0) m_pc = m_ras.pop_back();
          else begin
            m_pc  = m_pc + 1;
            e.unf = 1'b1;
          end
        end
        default: m_pc = m_pc + 1;
      endcase
    end
    e.pc    = m_pc;
    e.count = m_ras.size();
    sb.push_back(e);
  endtask

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: the DUT presents a new registered state every cycle; compare it
  // away from the rising edge against the oldest pending expectation.
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("pc",        pc,                   e.pc);
      chk("ras_count", W'(ras_count),        W'(e.count));
      chk("ras_empty", W'(ras_empty),        W'(e.count == 0));
      chk("ras_full",  W'(ras_full),         W'(e.count == DEPTH));
      chk("overflow",  W'(ras_ovf),          W'(e.ovf));
      chk("underflow", W'(ras_unf),          W'(e.unf));
    end
  end

  initial begin
    rst_n  = 1'b0;
    stall  = 1'b0;
    op     = 3'd0;
    offset = '0;
    target = '0;
    m_pc   = RV;

    // Reset holds PC even with a JUMP presented.
    step(0, 0, 3'd2, 0, 32'h55);
    step(0, 1, 3'd3, 0, 32'h77);
    // Sequential counting.
    repeat (3) step(1, 0, 3'd0, 0, 0);
    // Branch arithmetic and wrap-around.
    step(1, 0, 3'd2, 0, 32'd10);
    step(1, 0, 3'd1, 32'd42, 0);
    step(1, 0, 3'd1, 32'hFFFF_FFC4, 0);
    step(1, 0, 3'd2, 0, 32'hFFFF_FFFF);
    step(1, 0, 3'd0, 0, 0);
    // Undefined op codes behave as SEQ.
    step(1, 0, 3'd5, 32'd9, 32'd9);
    step(1, 0, 3'd7, 32'd9, 32'd9);
    // Call / return.
    step(1, 0, 3'd2, 0, 32'd5);
    step(1, 0, 3'd3, 0, 32'd100);
    step(1, 0, 3'd0, 0, 0);
    step(1, 0, 3'd0, 0, 0);
    step(1, 0, 3'd4, 0, 0);
    // Five nested calls overflow a 4-deep stack, then unwind.
    step(1, 0, 3'd2, 0, 32'd0);
    for (int i = 1; i <= 5; i++) step(1, 0, 3'd3, 0, W'(i * 100));
    repeat (4) step(1, 0, 3'd4, 0, 0);
    // Return on empty stack.
    step(1, 0, 3'd2, 0, 32'd7);
    step(1, 0, 3'd4, 0, 0);
    step(1, 0, 3'd0, 0, 0);
    // Stall discards a JUMP.
    repeat (3) step(1, 1, 3'd2, 0, 32'h80);
    step(1, 0, 3'd0, 0, 0);
    // Stalled CALL/RET leave the stack alone.
    step(1, 0, 3'd3, 0, 32'h200);
    step(1, 1, 3'd4, 0, 0);
    step(1, 1, 3'd3, 0, 32'h300);
    // Reset mid-sequence discards return addresses.
    step(1, 0, 3'd3, 0, 32'h400);
    step(0, 0, 3'd4, 0, 0);
    step(1, 0, 3'd4, 0, 0);
    step(1, 0, 3'd0, 0, 0);

    // Random ops, biased toward calls and returns.
    for (int i = 0; i < 600; i++) begin
      logic       r, s;
      logic [2:0] o;
      int unsigned k;
      r = ($urandom_range(0, 99) >= 2);
      s = ($urandom_range(0, 99) < 10);
      k = $urandom_range(0, 9);
      case (k)
        0, 1:    o = 3'd3;
        2, 3:    o = 3'd4;
        4:       o = 3'd1;
        5:       o = 3'd2;
        6:       o = 3'($urandom_range(5, 7));
        default: o = 3'd0;
      endcase
      step(r, s, o, $urandom, $urandom);
    end

    // Drain: every expectation must be consumed within a bounded number of cycles.
    for (int i = 0; i < 4 && sb.size() > 0; i++) @(posedge clk);
    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
